// File: rtl/buffer_read_ctrl_if.sv
// Raster position in, line-buffer RAM read port out.
// The controller takes the master side; the RAM/timing side takes the slave side.
interface buffer_read_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int CNT_WIDTH  = 12
);
    logic [CNT_WIDTH-1:0]  counterX;
    logic [CNT_WIDTH-1:0]  counterY;
    logic [ADDR_WIDTH-1:0] rdaddr;
    logic                  rden;
    logic                  pixel_valid;

    modport master (
        input  counterX,
        input  counterY,
        output rdaddr,
        output rden,
        output pixel_valid
    );

    modport slave (
        output counterX,
        output counterY,
        input  rdaddr,
        input  rden,
        input  pixel_valid
    );
endinterface

// File: rtl/buffer_read_ctrl.sv
// Read-side sequencer for the capture line buffer: arms on the write-side trigger,
// syncs to the output frame origin, then issues one RAM read per active output pixel.
//
//   state | meaning
//   IDLE  | waiting for starttrigger while enabled
//   ARMED | trigger seen, waiting for raster origin (0,0)
//   RUN   | generating reads; line base restarts at every frame origin
module buffer_read_ctrl #(
    parameter int ADDR_WIDTH  = 15,
    parameter int CNT_WIDTH   = 12,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  starttrigger,
    input  logic [CNT_WIDTH-1:0]  h_active_start,
    input  logic [CNT_WIDTH-1:0]  h_active_end,
    input  logic [CNT_WIDTH-1:0]  v_active_start,
    input  logic [CNT_WIDTH-1:0]  v_active_end,
    input  logic [ADDR_WIDTH-1:0] buffer_line_length,
    input  logic [ADDR_WIDTH-1:0] ram_numwords,
    input  logic                  repeat_lines,
    buffer_read_ctrl_if.master    bus,
    output logic                  frame_start,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic                    line_phase;
    logic [CNT_WIDTH-1:0]    counterX_prev;
    logic [RAM_LATENCY-1:0]  valid_pipe;

    logic                    frame_origin;
    logic                    h_active;
    logic                    v_active;
    logic                    read_now;
    logic                    line_end_edge;
    logic                    line_advance;
    logic [CNT_WIDTH-1:0]    x_offset;
    logic [ADDR_WIDTH-1:0]   read_addr;
    logic [ADDR_WIDTH-1:0]   wrap_limit;

    assign frame_origin  = (bus.counterX == '0) && (bus.counterY == '0);
    assign h_active      = (bus.counterX >= h_active_start) && (bus.counterX < h_active_end);
    assign v_active      = (bus.counterY >= v_active_start) && (bus.counterY < v_active_end);
    assign read_now      = (state_q == RUN) && enable && h_active && v_active;

    // Edge on the end-of-line column so a stalled counter advances only once.
    assign line_end_edge = (bus.counterX == h_active_end) && (counterX_prev != h_active_end);
    assign line_advance  = (state_q == RUN) && enable && v_active && line_end_edge;

    assign x_offset      = bus.counterX - h_active_start;
    assign read_addr     = line_base + ADDR_WIDTH'(x_offset);
    assign wrap_limit    = ram_numwords - buffer_line_length;

    assign state           = state_q;
    assign bus.pixel_valid = valid_pipe[RAM_LATENCY-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bus.rdaddr    <= '0;
            bus.rden      <= 1'b0;
            frame_start   <= 1'b0;
            line_base     <= '0;
            line_phase    <= 1'b0;
            counterX_prev <= '0;
            valid_pipe    <= '0;
        end else begin
            counterX_prev <= bus.counterX;
            frame_start   <= 1'b0;

            // Tracks RAM read latency; keeps draining after leaving RUN.
            valid_pipe[0] <= bus.rden;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end

            bus.rden <= read_now;
            if (read_now) begin
                bus.rdaddr <= read_addr;
            end

            case (state_q)
                IDLE: begin
                    if (enable && starttrigger) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (frame_origin) begin
                        state_q     <= RUN;
                        line_base   <= '0;
                        line_phase  <= 1'b0;
                        frame_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (frame_origin) begin
                        line_base   <= '0;
                        line_phase  <= 1'b0;
                        frame_start <= 1'b1;
                    end else if (line_advance) begin
                        if (repeat_lines && !line_phase) begin
                            line_phase <= 1'b1;
                        end else begin
                            line_phase <= 1'b0;
                            if (line_base < wrap_limit) begin
                                line_base <= line_base + buffer_line_length;
                            end else begin
                                line_base <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Directed bench for buffer_read_ctrl: arming, read addressing, line repeat, wrap,
// stalled counters, read-latency tracking, enable drop and asynchronous reset.
module tb_buffer_read_ctrl;
    localparam int AW = 15;
    localparam int CW = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          starttrigger;
    logic [CW-1:0] h_active_start, h_active_end, v_active_start, v_active_end;
    logic [AW-1:0] buffer_line_length, ram_numwords;
    logic          repeat_lines;
    logic          frame_start;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    buffer_read_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) rif ();

    buffer_read_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .RAM_LATENCY(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .starttrigger       (starttrigger),
        .h_active_start     (h_active_start),
        .h_active_end       (h_active_end),
        .v_active_start     (v_active_start),
        .v_active_end       (v_active_end),
        .buffer_line_length (buffer_line_length),
        .ram_numwords       (ram_numwords),
        .repeat_lines       (repeat_lines),
        .bus                (rif.master),
        .frame_start        (frame_start),
        .state              (state)
    );

    always #5 clock = ~clock;

    // Called at a negedge: drive counters, return at the next negedge with outputs updated.
    task automatic tick(input int x, input int y);
        rif.counterX = CW'(x);
        rif.counterY = CW'(y);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++;
        if (rif.rden !== 1'b0 || rif.pixel_valid !== 1'b0 || frame_start !== 1'b0 || rif.rdaddr !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rden=%b pv=%b fs=%b addr=%0d want all 0",
                     rif.rden, rif.pixel_valid, frame_start, rif.rdaddr);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_trigger_disabled();
        enable = 1'b0;
        starttrigger = 1'b1;
        tick(0, 100);
        starttrigger = 1'b0;
        tick(10, 0);
        n_checks++;
        if (state !== 2'd0 || rif.rden !== 1'b0) begin
            n_fail++; $display("FAIL trig_disabled got state=%0d rden=%b want 0 0", state, rif.rden);
        end
    endtask

    task automatic test_arm_and_first_line();
        enable = 1'b1;
        starttrigger = 1'b1;
        tick(0, 100);
        starttrigger = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL armed_state got %0d want 1", state); end
        starttrigger = 1'b1;
        tick(5, 100);
        starttrigger = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL armed_retrigger got %0d want 1", state); end
        tick(0, 0);
        n_checks++;
        if (state !== 2'd2 || frame_start !== 1'b1) begin
            n_fail++; $display("FAIL run_entry got state=%0d fs=%b want 2 1", state, frame_start);
        end
        tick(1, 0);
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_one_cycle got %b want 0", frame_start); end
        tick(10, 0);
        n_checks++;
        if (rif.rden !== 1'b1 || rif.rdaddr !== 15'd0 || rif.pixel_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_pixel got rden=%b addr=%0d pv=%b want 1 0 0",
                               rif.rden, rif.rdaddr, rif.pixel_valid);
        end
        tick(11, 0);
        n_checks++;
        if (rif.rdaddr !== 15'd1 || rif.pixel_valid !== 1'b0) begin
            n_fail++; $display("FAIL second_pixel got addr=%0d pv=%b want 1 0", rif.rdaddr, rif.pixel_valid);
        end
        tick(12, 0);
        n_checks++;
        if (rif.pixel_valid !== 1'b1) begin n_fail++; $display("FAIL pv_rise got %b want 1", rif.pixel_valid); end
        starttrigger = 1'b1;
        tick(648, 0);
        starttrigger = 1'b0;
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL run_ignores_trig got %0d want 2", state); end
        tick(649, 0);
        n_checks++;
        if (rif.rdaddr !== 15'd639 || rif.rden !== 1'b1) begin
            n_fail++; $display("FAIL last_pixel got addr=%0d rden=%b want 639 1", rif.rdaddr, rif.rden);
        end
        tick(650, 0);
        n_checks++;
        if (rif.rden !== 1'b0 || rif.rdaddr !== 15'd639 || rif.pixel_valid !== 1'b1) begin
            n_fail++; $display("FAIL line_end got rden=%b addr=%0d pv=%b want 0 639 1",
                               rif.rden, rif.rdaddr, rif.pixel_valid);
        end
        tick(651, 0);
        n_checks++;
        if (rif.pixel_valid !== 1'b1) begin n_fail++; $display("FAIL pv_tail got %b want 1", rif.pixel_valid); end
        tick(652, 0);
        n_checks++;
        if (rif.pixel_valid !== 1'b0) begin n_fail++; $display("FAIL pv_fall got %b want 0", rif.pixel_valid); end
        tick(10, 1);
        n_checks++;
        if (rif.rdaddr !== 15'd640) begin n_fail++; $display("FAIL line1_base got %0d want 640", rif.rdaddr); end
        tick(650, 1);
    endtask

    task automatic test_repeat_lines();
        int exp_base [5] = '{0, 0, 640, 640, 1280};
        repeat_lines = 1'b1;
        tick(0, 0);
        n_checks++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL fs_origin got %b want 1", frame_start); end
        for (int y = 0; y < 5; y++) begin
            tick(10, y);
            n_checks++;
            if (rif.rdaddr !== AW'(exp_base[y])) begin
                n_fail++; $display("FAIL repeat_line%0d got %0d want %0d", y, rif.rdaddr, exp_base[y]);
            end
            tick(650, y);
        end
        repeat_lines = 1'b0;
    endtask

    task automatic test_wrap();
        tick(0, 0);
        for (int y = 0; y < 26; y++) begin
            tick(10, y);
            n_checks++;
            if (rif.rdaddr !== AW'((y % 25) * 640)) begin
                n_fail++; $display("FAIL wrap_line%0d got %0d want %0d", y, rif.rdaddr, (y % 25) * 640);
            end
            tick(650, y);
        end
        tick(0, 0);
        tick(10, 0);
        n_checks++;
        if (rif.rdaddr !== 15'd0) begin n_fail++; $display("FAIL origin_rebase got %0d want 0", rif.rdaddr); end
    endtask

    task automatic test_stall();
        tick(0, 0);
        tick(10, 0);
        repeat (3) tick(650, 0);
        tick(10, 1);
        n_checks++;
        if (rif.rdaddr !== 15'd640) begin n_fail++; $display("FAIL stall_base got %0d want 640", rif.rdaddr); end
    endtask

    task automatic test_enable_drop();
        tick(298, 5);
        tick(299, 5);
        enable = 1'b0;
        tick(300, 5);
        n_checks++;
        if (state !== 2'd0 || rif.rden !== 1'b0 || rif.pixel_valid !== 1'b1) begin
            n_fail++; $display("FAIL en_drop got state=%0d rden=%b pv=%b want 0 0 1",
                               state, rif.rden, rif.pixel_valid);
        end
        tick(301, 5);
        n_checks++;
        if (rif.pixel_valid !== 1'b1) begin n_fail++; $display("FAIL en_drain1 got %b want 1", rif.pixel_valid); end
        tick(302, 5);
        n_checks++;
        if (rif.pixel_valid !== 1'b0) begin n_fail++; $display("FAIL en_drain2 got %b want 0", rif.pixel_valid); end
        enable = 1'b1;
        starttrigger = 1'b1;
        tick(0, 100);
        starttrigger = 1'b0;
        enable = 1'b0;
        tick(0, 0);
        n_checks++;
        if (state !== 2'd0 || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL en_low_origin got state=%0d fs=%b want 0 0", state, frame_start);
        end
    endtask

    task automatic test_reset_midline();
        enable = 1'b1;
        starttrigger = 1'b1;
        tick(0, 100);
        starttrigger = 1'b0;
        tick(0, 0);
        tick(10, 0);
        tick(11, 0);
        tick(12, 0);
        n_checks++;
        if (rif.rden !== 1'b1 || rif.pixel_valid !== 1'b1 || rif.rdaddr !== 15'd2) begin
            n_fail++; $display("FAIL pre_reset got rden=%b pv=%b addr=%0d want 1 1 2",
                               rif.rden, rif.pixel_valid, rif.rdaddr);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'd0 || rif.rden !== 1'b0 || rif.pixel_valid !== 1'b0 ||
            rif.rdaddr !== '0 || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got state=%0d rden=%b pv=%b addr=%0d fs=%b want all 0",
                               state, rif.rden, rif.pixel_valid, rif.rdaddr, frame_start);
        end
        @(negedge clock);
        reset = 1'b0;
        tick(13, 0);
        n_checks++;
        if (state !== 2'd1 - 2'd1 || rif.rden !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got state=%0d rden=%b want 0 0", state, rif.rden);
        end
    endtask

    initial begin
        reset              = 1'b1;
        enable             = 1'b0;
        starttrigger       = 1'b0;
        repeat_lines       = 1'b0;
        h_active_start     = 12'd10;
        h_active_end       = 12'd650;
        v_active_start     = 12'd0;
        v_active_end       = 12'd480;
        buffer_line_length = 15'd640;
        ram_numwords       = 15'd16000;
        rif.counterX       = '0;
        rif.counterY       = 12'd100;
        @(negedge clock);

        test_reset();
        test_trigger_disabled();
        test_arm_and_first_line();
        test_repeat_lines();
        test_wrap();
        test_stall();
        test_enable_drop();
        test_reset_midline();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/buffer_read_ctrl.md
Name: buffer_read_ctrl

Overview:
- Read-side sequencer for the capture line-buffer RAM filled by the video capture write path.
- Arms on the write path's start trigger and waits for the output raster's frame origin.
- Then generates RAM read address/enable per output pixel, with optional line repeat and wrap at the buffer size.
- Sits between the output timing generator and the line-buffer RAM read port, in the output clock domain.

Parameters:
ADDR_WIDTH, 15, RAM address width
CNT_WIDTH, 12, raster counter width
RAM_LATENCY, 2, cycles from rden to valid RAM read data

Ports:
clock  in  1  output pixel clock
reset  in  1  asynchronous, active-high reset
enable  in  1  controller enable
starttrigger  in  1  one-cycle pulse from write side; already synchronized to clock
counterX  in  CNT_WIDTH  output raster X
counterY  in  CNT_WIDTH  output raster Y
h_active_start  in  CNT_WIDTH  first active X
h_active_end  in  CNT_WIDTH  exclusive last active X
v_active_start  in  CNT_WIDTH  first active Y
v_active_end  in  CNT_WIDTH  exclusive last active Y
buffer_line_length  in  ADDR_WIDTH  words per buffer line
ram_numwords  in  ADDR_WIDTH  total RAM words
repeat_lines  in  1  output each buffer line twice
rdaddr  out  ADDR_WIDTH  RAM read address
rden  out  1  RAM read enable
pixel_valid  out  1  RAM output data valid
frame_start  out  1  one-cycle pulse on entering RUN and at each frame origin in RUN
state  out  2  0=IDLE, 1=ARMED, 2=RUN

Behaviour:
- Reset (async, any time, including mid-RUN):
  - state=IDLE; rdaddr=0, rden=0, pixel_valid=0, frame_start=0.
  - line_base=0, line_phase=0, counterX_prev=0.
  - Latency pipeline cleared.
- IDLE:
  - enable=1 and starttrigger=1 in the same cycle -> ARMED.
  - Trigger with enable=0 is ignored.
- ARMED:
  - Transition to RUN on the cycle counterX==0 and counterY==0.
  - On that transition: line_base=0, line_phase=0, frame_start=1 for one cycle.
  - Further triggers are ignored.
- RUN:
  - starttrigger is ignored.
  - At each frame origin (0,0): line_base=0, line_phase=0, frame_start pulses.
- enable=0 in ARMED or RUN -> IDLE the next cycle; rden=0 from that cycle on.
- Read generation (registered, 1-cycle latency from counters):
  - In RUN with v_active_start<=counterY<v_active_end and h_active_start<=counterX<h_active_end:
    - rden=1
    - rdaddr = line_base + (counterX - h_active_start), truncated to ADDR_WIDTH.
  - Otherwise rden=0 and rdaddr holds its last value.
- Line advance:
  - Triggered on the first cycle where counterX==h_active_end and counterX_prev!=h_active_end. A stalled counter advances only once.
  - Applies only in RUN with counterY inside the vertical active window.
  - repeat_lines=1 and line_phase=0 -> line_phase=1, base unchanged.
  - Otherwise line_phase=0, and:
    - If line_base < ram_numwords - buffer_line_length: line_base += buffer_line_length.
    - Else line_base=0 (wrap).
  - repeat_lines changing mid-frame takes effect at the next advance.
- pixel_valid:
  - Equals rden delayed by exactly RAM_LATENCY cycles via a shift register.
  - In-flight reads still raise pixel_valid after leaving RUN.
  - Only reset flushes the pipeline.
- Simultaneous events:
  - Frame origin and line advance at the same cycle: the frame-origin reset wins.
  - enable=0 and frame origin at the same cycle: go to IDLE, no frame_start.

Test Plan:
- Reset, enable=0, starttrigger pulse at Y=100 -> state stays 0, rden=0.
- enable=1; window X 10..650, Y 0..480; len=640; numwords=16000. Trigger at Y=100 -> state=1. At (0,0) -> state=2 and frame_start=1 for one cycle. Counters (10,0) -> next cycle rden=1, rdaddr=0. (649,0) -> rdaddr=639. (650,0) -> rden=0.
- Line advance: at (10,1) rdaddr=640. With repeat_lines=1: lines 0 and 1 start at 0, lines 2 and 3 start at 640, line 4 starts at 1280.
- Wrap: numwords=16000, len=640 -> line 24 base 15360, line 25 base 0. Next frame origin forces base 0 regardless of line count.
- Stall: counterX held at 650 for 3 cycles on line 0 -> line 1 base 640 (single advance), not 1920.
- RAM_LATENCY=2: pixel_valid rises 2 cycles after rden, falls 2 cycles after rden falls.
  - Drop enable at (300,5) -> state=0, rden=0 next cycle, pixel_valid drains after 2 more cycles.
  - Assert reset mid-line -> all outputs 0 immediately.
